// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops return on the next edge, and MUL takes WIDTH edges (one multiplier bit per cycle).
// The result is held in HOLD until out_ready. A new op is accepted in the same edge that the held result is consumed.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc,
    output logic             carry,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_LSHF  = 3'b100;
    localparam logic [2:0] OP_RSHFL = 3'b101;
    localparam logic [2:0] OP_RSHFA = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             mul_last;
    logic [SHW-1:0]   mul_cnt;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [SHW-1:0]   sh;

    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])    return 3'b100;
        else if (v == '0)  return 3'b010;
        else               return 3'b001;
    endfunction

    // Gating on reset_n keeps in_ready low for the whole time reset is asserted.
    assign in_ready  = reset_n && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_HOLD);
    assign mul_last  = (state == S_MUL) && (mul_cnt == SHW'(WIDTH - 1));
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign sum       = {1'b0, a} + {1'b0, b};
    assign sh        = b[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD:   begin alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
            OP_AND:   alu_res = a & b;
            OP_XOR:   alu_res = a ^ b;
            OP_PASSA: alu_res = a;
            OP_LSHF:  alu_res = a << sh;
            OP_RSHFL: alu_res = a >> sh;
            OP_RSHFA: alu_res = $signed(a) >>> sh;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (op == OP_MUL) ? S_MUL : S_HOLD;
            S_MUL:  if (mul_last) state_nxt = S_HOLD;
            S_HOLD: begin
                if (accept)         state_nxt = (op == OP_MUL) ? S_MUL : S_HOLD;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result  <= '0;
            cc      <= 3'b010;
            carry   <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_cnt <= '0;
        end else begin
            if (accept && (op != OP_MUL)) begin
                result <= alu_res;
                cc     <= cc_of(alu_res);
                carry  <= alu_carry;
            end
            if (accept && (op == OP_MUL)) begin
                mcand   <= a;
                mplier  <= b;
                acc     <= '0;
                mul_cnt <= '0;
            end else if (state == S_MUL) begin
                // Shift-add: bits of the multiplicand above WIDTH are discarded, giving the low half directly.
                acc     <= acc_step;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                mul_cnt <= mul_cnt + SHW'(1);
                if (mul_last) begin
                    result <= acc_step;
                    cc     <= cc_of(acc_step);
                    carry  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16: a vector table of single-cycle ops issued back to back,
// plus hand-written MUL, hold, and reset-during-MUL sequences.
module tb_alu_seq;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         in_valid, in_ready;
    logic [W-1:0] result;
    logic [2:0]   cc;
    logic         carry, out_valid, out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op       (op),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .cc       (cc),
        .carry    (carry),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [2:0]   cc;
        logic         carry;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input string n, input logic [2:0] o, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic [W-1:0] r,
                                input logic [2:0] c, input logic cy);
        vec_t v;
        v.name = n; v.op = o; v.a = av; v.b = bv; v.res = r; v.cc = c; v.carry = cy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string n, input logic [W-1:0] r, input logic [2:0] c, input logic cy);
        check({n, ".out_valid"}, 64'(out_valid), 64'(1'b1));
        check({n, ".result"},    64'(result),    64'(r));
        check({n, ".cc"},        64'(cc),        64'(c));
        check({n, ".carry"},     64'(carry),     64'(cy));
    endtask

    // Enters at a negedge with the DUT able to accept; leaves at the negedge after the result appears, with out_ready=0.
    task automatic mul_run(input string n, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] r, input logic [2:0] c);
        op = 3'b111; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0; a = '1; b = '1; op = 3'b000;
        #1;
        check({n, ".valid_after_accept"}, 64'(out_valid), 64'(1'b0));
        check({n, ".ready_after_accept"}, 64'(in_ready),  64'(1'b0));
        for (int k = 1; k < W; k++) begin
            @(negedge clock);
            check({n, ".busy_valid"}, 64'(out_valid), 64'(1'b0));
            check({n, ".busy_ready"}, 64'(in_ready),  64'(1'b0));
        end
        @(negedge clock);
        expect_out(n, r, c, 1'b0);
    endtask

    initial begin
        vecs[0]  = mk("add_7fff_1",  3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b0);
        vecs[1]  = mk("add_ffff_1",  3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1'b1);
        vecs[2]  = mk("xor",         3'b010, 16'h00FF, 16'h0F0F, 16'h0FF0, 3'b001, 1'b0);
        vecs[3]  = mk("rshfa_8000",  3'b110, 16'h8000, 16'h0004, 16'hF800, 3'b100, 1'b0);
        vecs[4]  = mk("rshfl_8000",  3'b101, 16'h8000, 16'h0004, 16'h0800, 3'b001, 1'b0);
        vecs[5]  = mk("lshf_1_15",   3'b100, 16'h0001, 16'h000F, 16'h8000, 3'b100, 1'b0);
        vecs[6]  = mk("lshf_by_0",   3'b100, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1'b0);
        vecs[7]  = mk("add_plain",   3'b000, 16'h1234, 16'h1111, 16'h2345, 3'b001, 1'b0);
        vecs[8]  = mk("and",         3'b001, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b001, 1'b0);
        vecs[9]  = mk("passa_zero",  3'b011, 16'h0000, 16'hFFFF, 16'h0000, 3'b010, 1'b0);
        vecs[10] = mk("rshfa_pos",   3'b110, 16'h7000, 16'h0004, 16'h0700, 3'b001, 1'b0);
        vecs[11] = mk("add_8000x2",  3'b000, 16'h8000, 16'h8000, 16'h0000, 3'b010, 1'b1);
        vecs[12] = mk("shamt_high",  3'b100, 16'h0003, 16'hFFF1, 16'h0006, 3'b001, 1'b0);

        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst.out_valid", 64'(out_valid), 64'(1'b0));
        check("rst.result",    64'(result),    64'(16'h0000));
        check("rst.cc",        64'(cc),        64'(3'b010));
        check("rst.carry",     64'(carry),     64'(1'b0));
        check("rst.in_ready",  64'(in_ready),  64'(1'b0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 check("rst_release.in_ready", 64'(in_ready), 64'(1'b1));

        // Table issued back to back: each result is consumed in the edge that accepts the next op.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            #1 check({vecs[i].name, ".in_ready"}, 64'(in_ready), 64'(1'b1));
            @(negedge clock);
            expect_out(vecs[i].name, vecs[i].res, vecs[i].cc, vecs[i].carry);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("drain.out_valid", 64'(out_valid), 64'(1'b0));

        mul_run("mul_3x5", 16'h0003, 16'h0005, 16'h000F, 3'b001);
        repeat (3) begin
            @(negedge clock);
            expect_out("mul_3x5_hold", 16'h000F, 3'b001, 1'b0);
            check("mul_3x5_hold.in_ready", 64'(in_ready), 64'(1'b0));
        end
        out_ready = 1'b1;
        #1 check("hold_release.in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clock);
        check("mul_3x5_consumed.out_valid", 64'(out_valid), 64'(1'b0));

        // MUL accepted directly out of HOLD.
        op = 3'b000; a = 16'h0001; b = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        expect_out("add_before_mul", 16'h0002, 3'b001, 1'b0);
        mul_run("mul_ff_ff",     16'h00FF, 16'h00FF, 16'hFE01, 3'b100);
        mul_run("mul_ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 3'b001);
        mul_run("mul_1234_0100", 16'h1234, 16'h0100, 16'h3400, 3'b001);

        // Reset during the 5th MUL cycle.
        op = 3'b000; a = 16'h8000; b = 16'h8001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        expect_out("add_carry", 16'h0001, 3'b001, 1'b1);
        op = 3'b111; a = 16'h0003; b = 16'h0005;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_mul_rst.out_valid", 64'(out_valid), 64'(1'b0));
        check("mid_mul_rst.result",    64'(result),    64'(16'h0000));
        check("mid_mul_rst.cc",        64'(cc),        64'(3'b010));
        check("mid_mul_rst.carry",     64'(carry),     64'(1'b0));
        check("mid_mul_rst.in_ready",  64'(in_ready),  64'(1'b0));
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("mid_mul_release.in_ready", 64'(in_ready), 64'(1'b1));
        repeat (20) @(negedge clock);
        check("discarded_mul.out_valid", 64'(out_valid), 64'(1'b0));
        op = 3'b000; a = 16'h0002; b = 16'h0003; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        expect_out("add_after_rst", 16'h0005, 3'b001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be a power of two in 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 op  input  3  operation select: 000 ADD, 001 AND, 010 XOR, 011 PASSA, 100 LSHF, 101 RSHFL, 110 RSHFA, 111 MUL.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand; for shifts, b[SHW-1:0] is the shift amount.
REQ-008 in_valid  input  1  op/a/b valid this cycle.
REQ-009 in_ready  output  1  block can accept an operation this cycle.
REQ-010 result  output  WIDTH  registered result.
REQ-011 cc  output  3  registered condition codes {n,z,p} of result.
REQ-012 carry  output  1  registered carry-out of ADD; 0 for all other ops.
REQ-013 out_valid  output  1  result/cc/carry valid.
REQ-014 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-015 An operation SHALL be accepted on a rising edge where in_valid && in_ready; op/a/b are captured then and may change afterwards.
REQ-016 States: IDLE, MUL, HOLD; HOLD means out_valid=1.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in HOLD when out_ready=1, and 0 otherwise (always 0 in MUL).
REQ-018 Single-cycle ops (000-110) SHALL present result with out_valid=1 on the edge after acceptance, i.e. latency 1, and enter HOLD.
REQ-019 ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-020 AND, XOR: bitwise; PASSA: result = a.
REQ-021 LSHF: a shifted left, zero fill; RSHFL: a shifted right, zero fill; RSHFA: a shifted right, sign fill; amount 0 SHALL return a unchanged.
REQ-022 MUL: low WIDTH bits of unsigned a*b, computed by iterative shift-add, one multiplier bit per cycle; the state machine stays in MUL for exactly WIDTH cycles after acceptance, and out_valid rises on the WIDTH-th edge after the accepting edge.
REQ-023 cc SHALL be 100 if result[WIDTH-1]=1, 010 if result=0, otherwise 001; exactly one bit is always set.
REQ-024 In HOLD, result/cc/carry/out_valid SHALL stay stable while out_ready=0.
REQ-025 HOLD with out_ready=1 and no new acceptance: next state IDLE, out_valid 0.
REQ-026 HOLD with out_ready=1 and a simultaneous acceptance: the old result is consumed and the new op loads in the same edge, giving a throughput of one single-cycle op per clock.
REQ-027 A new op accepted from HOLD that is MUL SHALL drop out_valid on that edge and enter MUL.
REQ-028 in_valid while in_ready=0 SHALL be ignored, with no capture; the producer holds it.
REQ-029 Undefined states SHALL return to IDLE on the next edge.

Reset
REQ-030 While reset_n=0, independent of clock: state IDLE, result 0, cc 010, carry 0, out_valid 0, and the MUL counter/accumulator 0.
REQ-031 Reset during MUL or HOLD SHALL discard the operation; no out_valid is produced for it.
REQ-032 in_ready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.

Verification (WIDTH=16)
REQ-033 ADD a=7FFF b=0001 -> on the next edge: result 8000, cc 100, carry 0, out_valid 1.
REQ-034 ADD FFFF+0001 -> result 0000, cc 010, carry 1; then XOR 00FF^0F0F -> 0FF0, cc 001.
REQ-035 RSHFA 8000 by b=0004 -> F800 cc 100; RSHFL 8000 by 4 -> 0800; LSHF 0001 by 15 -> 8000; LSHF 1234 by 0 -> 1234.
REQ-036 MUL 0003*0005 -> in_ready 0 for 16 cycles, out_valid on the 16th edge, result 000F; hold out_ready=0 for 3 cycles -> outputs unchanged; then out_ready=1 -> out_valid 0.
REQ-037 Back-to-back ADD, AND, PASSA with in_valid=1 and out_ready=1 -> one result per cycle, in order, no bubbles.
REQ-038 Assert reset_n=0 on the 5th MUL cycle -> out_valid, result and carry become 0 and cc 010 immediately; after release in_ready=1 and ADD 0002+0003 -> 0005.
